// File: rtl/fpnew_pkg.sv
// Floating-point format descriptors shared by the arithmetic blocks.
// Only the width queries needed by the reduction datapath.
package fpnew_pkg;

   typedef enum logic [2:0] {
      FP32,
      FP64,
      FP16,
      FP8,
      FP16ALT
   } fp_format_e;

   function automatic int unsigned exp_bits(fp_format_e f);
      case (f)
         FP32:    return 8;
         FP64:    return 11;
         FP16:    return 5;
         FP8:     return 5;
         default: return 8;
      endcase
   endfunction

   function automatic int unsigned man_bits(fp_format_e f);
      case (f)
         FP32:    return 23;
         FP64:    return 52;
         FP16:    return 10;
         FP8:     return 2;
         default: return 7;
      endcase
   endfunction

   function automatic int unsigned fp_width(fp_format_e f);
      return 1 + exp_bits(f) + man_bits(f);
   endfunction

endpackage

// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE row reduction unit.
// Reduction opcodes and the reducer FSM state encoding.
package redmule_pkg;

   typedef enum logic [1:0] {
      RED_SUM,
      RED_MAX,
      RED_MIN,
      RED_ABSMAX
   } red_op_e;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } red_state_e;

endpackage

// File: rtl/redmule_fma.sv
// Pipelined floating-point adder lane, round-to-nearest-even.
// Result emerges NumPipeRegs cycles after launch; flush_i empties it.
module redmule_fma
   import fpnew_pkg::*;
#(
   parameter fp_format_e  FpFormat    = FP16,
   parameter int unsigned NumPipeRegs = 1,
   localparam int unsigned BITW       = fp_width(FpFormat)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            valid_i,
   input  logic [BITW-1:0] a_i,
   input  logic [BITW-1:0] b_i,
   output logic [BITW-1:0] res_o,
   output logic            valid_o
);

   localparam int unsigned E = exp_bits(FpFormat);
   localparam int unsigned M = man_bits(FpFormat);
   localparam int unsigned S = M + 4;
   localparam logic [E+1:0] ONE  = 1;
   localparam logic [E+1:0] EMAX = {2'b00, {E{1'b1}}};
   localparam logic [BITW-1:0] QNAN =
      {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

   logic [BITW-1:0] big, sml, sum_r;
   logic            nan_a, nan_b, inf_a, inf_b;
   logic            sub, stk, rnd;
   logic [E+1:0]    eb, es, ex;
   logic [S-1:0]    gb, gs;
   logic [S:0]      acc;
   logic [M+1:0]    rs;
   int              sh;

   assign nan_a = (&a_i[BITW-2:M]) & (|a_i[M-1:0]);
   assign nan_b = (&b_i[BITW-2:M]) & (|b_i[M-1:0]);
   assign inf_a = (&a_i[BITW-2:M]) & ~(|a_i[M-1:0]);
   assign inf_b = (&b_i[BITW-2:M]) & ~(|b_i[M-1:0]);

   // Align, add, normalise and round a single sum
   always_comb begin
      if (a_i[BITW-2:0] >= b_i[BITW-2:0]) begin
         big = a_i;
         sml = b_i;
      end else begin
         big = b_i;
         sml = a_i;
      end
      sub = big[BITW-1] ^ sml[BITW-1];
      eb  = {2'b00, big[BITW-2:M]};
      es  = {2'b00, sml[BITW-2:M]};
      if (eb == '0) eb = ONE;
      if (es == '0) es = ONE;
      gb  = {|big[BITW-2:M], big[M-1:0], 3'b000};
      gs  = {|sml[BITW-2:M], sml[M-1:0], 3'b000};
      sh  = int'(eb) - int'(es);
      stk = 1'b0;
      for (int i = 0; i < S; i++) begin
         if (i < sh) begin
            stk = stk | gs[0];
            gs  = gs >> 1;
         end
      end
      gs[0] = gs[0] | stk;
      if (sub) acc = {1'b0, gb} - {1'b0, gs};
      else     acc = {1'b0, gb} + {1'b0, gs};
      ex = eb;
      if (acc[S]) begin
         acc = {1'b0, acc[S:2], acc[1] | acc[0]};
         ex  = ex + ONE;
      end else begin
         for (int i = 0; i < S; i++) begin
            if (!acc[S-1] && ex > ONE) begin
               acc = acc << 1;
               ex  = ex - ONE;
            end
         end
      end
      rnd = acc[2] & ((|acc[1:0]) | acc[3]);
      rs  = {1'b0, acc[S-1:3]} + {{(M+1){1'b0}}, rnd};
      if (rs[M+1]) begin
         rs = rs >> 1;
         ex = ex + ONE;
      end
      if (ex >= EMAX)
         sum_r = {big[BITW-1], {E{1'b1}}, {M{1'b0}}};
      else if (!rs[M])
         sum_r = {big[BITW-1], {E{1'b0}}, rs[M-1:0]};
      else
         sum_r = {big[BITW-1], ex[E-1:0], rs[M-1:0]};
      if (acc == '0)
         sum_r = sub ? '0 : {big[BITW-1], {(BITW-1){1'b0}}};
      if (nan_a || nan_b || (inf_a && inf_b && sub))
         sum_r = QNAN;
      else if (inf_a)
         sum_r = a_i;
      else if (inf_b)
         sum_r = b_i;
   end

   if (NumPipeRegs == 0) begin : g_comb
      assign res_o   = sum_r;
      assign valid_o = valid_i;
   end else begin : g_pipe
      logic [BITW-1:0]        pr_q [NumPipeRegs];
      logic [NumPipeRegs-1:0] pv_q;

      // Result/valid delay line; a flush drops everything in flight
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            pv_q <= '0;
            for (int i = 0; i < NumPipeRegs; i++) pr_q[i] <= '0;
         end else if (flush_i) begin
            pv_q <= '0;
         end else begin
            pv_q[0] <= valid_i;
            pr_q[0] <= sum_r;
            for (int i = 1; i < NumPipeRegs; i++) begin
               pv_q[i] <= pv_q[i-1];
               pr_q[i] <= pr_q[i-1];
            end
         end
      end

      assign res_o   = pr_q[NumPipeRegs-1];
      assign valid_o = pv_q[NumPipeRegs-1];
   end

endmodule

// File: rtl/redmule_row_reducer.sv
// Row reducer: folds a stream of element columns into one result
// per lane using SUM, MAX, MIN or ABSMAX.
module redmule_row_reducer
   import fpnew_pkg::*;
   import redmule_pkg::*;
#(
   parameter int unsigned Width    = 4,
   parameter fp_format_e  FpFormat = FP16,
   parameter int unsigned SumLat   = 1,
   parameter int unsigned CntWidth = 16,
   localparam int unsigned BITW    = fp_width(FpFormat)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  red_op_e               op_i,
   input  logic [CntWidth-1:0]   row_len_i,
   input  logic                  load_i,
   input  logic                  init_valid_i,
   input  logic [Width*BITW-1:0] init_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [Width*BITW-1:0] data_i,
   output logic [Width*BITW-1:0] red_o,
   output logic                  red_valid_o,
   input  logic                  red_ready_i,
   output logic                  busy_o
);

   localparam int unsigned E  = exp_bits(FpFormat);
   localparam int unsigned M  = man_bits(FpFormat);
   localparam int unsigned DW = Width * BITW;

   red_state_e          state_q, state_d;
   red_op_e             op_q, op_d;
   logic [DW-1:0]       red_q, red_d;
   logic [DW-1:0]       cmp_res, add_res;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [CntWidth-1:0] len_q, len_d;
   logic                pend_q, pend_d;
   logic                last_q, last_d;
   logic [Width-1:0]    add_vld;
   logic                add_valid, launch, lastel;

   function automatic logic [BITW-1:0] neutral(red_op_e op);
      case (op)
         RED_MAX: neutral = {1'b1, {E{1'b1}}, {M{1'b0}}};
         RED_MIN: neutral = {1'b0, {E{1'b1}}, {M{1'b0}}};
         default: neutral = '0;
      endcase
   endfunction

   for (genvar l = 0; l < Width; l++) begin : g_lane
      logic [BITW-1:0] r, d, kr, kd, nv;

      assign r  = red_q[l*BITW +: BITW];
      assign d  = data_i[l*BITW +: BITW];
      assign kr = r[BITW-1] ? ~r : {1'b1, r[BITW-2:0]};
      assign kd = d[BITW-1] ? ~d : {1'b1, d[BITW-2:0]};

      // Total-order compare; ties keep the running value
      always_comb begin
         nv = r;
         case (op_q)
            RED_MAX:
               if (kd > kr) nv = d;
            RED_MIN:
               if (kd < kr) nv = d;
            RED_ABSMAX:
               if (d[BITW-2:0] > r[BITW-2:0])
                  nv = {1'b0, d[BITW-2:0]};
            default: nv = r;
         endcase
      end

      assign cmp_res[l*BITW +: BITW] = nv;

      redmule_fma #(
         .FpFormat    (FpFormat),
         .NumPipeRegs (SumLat)
      ) i_fma (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (clear_i),
         .valid_i (launch),
         .a_i     (r),
         .b_i     (d),
         .res_o   (add_res[l*BITW +: BITW]),
         .valid_o (add_vld[l])
      );
   end

   assign add_valid = &add_vld;
   assign red_o     = red_q;
   assign busy_o    = (state_q != IDLE);

   // Next-state, accumulator update and handshake outputs
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      red_d       = red_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      pend_d      = pend_q;
      last_d      = last_q;
      in_ready_o  = 1'b0;
      red_valid_o = 1'b0;
      launch      = 1'b0;
      lastel      = (cnt_q == len_q - 1'b1);
      case (state_q)
         IDLE: begin
            if (!load_i || init_valid_i) begin
               op_d  = op_i;
               len_d = row_len_i;
               cnt_d = '0;
               red_d = load_i ? init_i
                              : {Width{neutral(op_i)}};
               state_d = (row_len_i == '0) ? DONE : ACC;
            end
         end
         ACC: begin
            in_ready_o = !pend_q;
            if (in_valid_i && !pend_q) begin
               cnt_d = lastel ? '0 : cnt_q + 1'b1;
               if (op_q == RED_SUM) begin
                  launch = 1'b1;
                  pend_d = (SumLat != 0);
                  last_d = lastel;
               end else begin
                  red_d = cmp_res;
                  if (lastel) state_d = DONE;
               end
            end
            if (add_valid) begin
               red_d  = add_res;
               pend_d = 1'b0;
               if (last_d) begin
                  last_d  = 1'b0;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            red_valid_o = 1'b1;
            if (red_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; clear flushes like reset but keeps op/len
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         op_q    <= RED_SUM;
         red_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         pend_q  <= 1'b0;
         last_q  <= 1'b0;
      end else if (clear_i) begin
         state_q <= IDLE;
         red_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         red_q   <= red_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         pend_q  <= pend_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_redmule_row_reducer.sv
// Directed bench for the row reducer (Width=4, FP16, SumLat=1).
// Expected values are hand-computed FP16 results.
module tb_redmule_row_reducer;
   import redmule_pkg::*;

   localparam int DW = 64;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          clear_i;
   red_op_e       op_i;
   logic [15:0]   row_len_i;
   logic          load_i;
   logic          init_valid_i;
   logic [DW-1:0] init_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] data_i;
   logic [DW-1:0] red_o;
   logic          red_valid_o;
   logic          red_ready_i;
   logic          busy_o;

   int n_checks = 0;
   int n_errors = 0;

   red_op_e       ops  [3];
   logic [DW-1:0] strm [3];
   logic [DW-1:0] exps [3];
   logic [4:0]    pat;

   always #5 clk_i = ~clk_i;

   redmule_row_reducer #(
      .Width    (4),
      .SumLat   (1),
      .CntWidth (16)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clear_i      (clear_i),
      .op_i         (op_i),
      .row_len_i    (row_len_i),
      .load_i       (load_i),
      .init_valid_i (init_valid_i),
      .init_i       (init_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .data_i       (data_i),
      .red_o        (red_o),
      .red_valid_o  (red_valid_o),
      .red_ready_i  (red_ready_i),
      .busy_o       (busy_o)
   );

   task automatic check(input string tag,
                        input logic [DW-1:0] got,
                        input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start(input red_op_e op,
                        input logic [15:0] len);
      op_i      = op;
      row_len_i = len;
      load_i    = 1'b0;
      tick();
      load_i    = 1'b1;
   endtask

   task automatic release_result();
      red_ready_i = 1'b1;
      tick();
      red_ready_i = 1'b0;
   endtask

   initial begin
      ops[0]  = RED_MAX;
      ops[1]  = RED_MIN;
      ops[2]  = RED_ABSMAX;
      strm[0] = 64'h7C00_4400_8000_C000;
      strm[1] = 64'hFC00_4400_0000_3C00;
      strm[2] = 64'h0001_3800_8000_BC00;
      exps[0] = 64'h7C00_4400_0000_3C00;
      exps[1] = 64'hFC00_3800_8000_C000;
      exps[2] = 64'h7C00_4400_0000_4000;
      pat     = 5'b10101;

      rst_i        = 1'b1;
      clear_i      = 1'b0;
      op_i         = RED_SUM;
      row_len_i    = 16'd0;
      load_i       = 1'b1;
      init_valid_i = 1'b0;
      init_i       = '0;
      in_valid_i   = 1'b0;
      data_i       = '0;
      red_ready_i  = 1'b0;
      #1;
      check("rst_red", red_o, 64'h0);
      check("rst_rvalid", DW'(red_valid_o), 64'h0);
      check("rst_inrdy", DW'(in_ready_o), 64'h0);
      check("rst_busy", DW'(busy_o), 64'h0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      tick();
      check("idle_busy", DW'(busy_o), 64'h0);
      check("idle_inrdy", DW'(in_ready_o), 64'h0);

      // SUM of three ones per lane
      start(RED_SUM, 16'd3);
      in_valid_i = 1'b1;
      data_i     = {4{16'h3C00}};
      for (int i = 0; i < 5; i++) begin
         check($sformatf("sum_rdy%0d", i),
               DW'(in_ready_o), DW'(pat[i]));
         if (i == 2)
            check("sum_part", red_o, {4{16'h3C00}});
         tick();
      end
      in_valid_i = 1'b0;
      check("sum_novalid", DW'(red_valid_o), 64'h0);
      tick();
      check("sum_valid", DW'(red_valid_o), 64'h1);
      check("sum_res", red_o, {4{16'h4200}});
      release_result();
      check("sum_idle", DW'(busy_o), 64'h0);

      // MAX / MIN / ABSMAX, op and len perturbed mid-row
      for (int k = 0; k < 3; k++) begin
         start(ops[k], 16'd3);
         op_i      = RED_SUM;
         row_len_i = 16'd7;
         for (int j = 0; j < 3; j++) begin
            data_i     = strm[j];
            in_valid_i = 1'b1;
            check($sformatf("cmp%0d_rdy%0d", k, j),
                  DW'(in_ready_o), 64'h1);
            tick();
         end
         in_valid_i = 1'b0;
         check($sformatf("cmp%0d_valid", k),
               DW'(red_valid_o), 64'h1);
         check($sformatf("cmp%0d_res", k), red_o, exps[k]);
         check($sformatf("cmp%0d_inrdy", k),
               DW'(in_ready_o), 64'h0);
         release_result();
      end

      // Start from supplied init, delayed init_valid
      op_i       = RED_SUM;
      row_len_i  = 16'd1;
      init_i     = {4{16'h4000}};
      in_valid_i = 1'b1;
      data_i     = {4{16'h3C00}};
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("ld_wait_busy%0d", i),
               DW'(busy_o), 64'h0);
         check($sformatf("ld_wait_rdy%0d", i),
               DW'(in_ready_o), 64'h0);
      end
      init_valid_i = 1'b1;
      tick();
      init_valid_i = 1'b0;
      check("ld_init", red_o, {4{16'h4000}});
      check("ld_rdy", DW'(in_ready_o), 64'h1);
      tick();
      in_valid_i = 1'b0;
      check("ld_novalid", DW'(red_valid_o), 64'h0);
      tick();
      check("ld_valid", DW'(red_valid_o), 64'h1);
      check("ld_res", red_o, {4{16'h4200}});

      // Backpressure in DONE keeps the result stable
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("hold_valid%0d", i),
               DW'(red_valid_o), 64'h1);
         check($sformatf("hold_res%0d", i),
               red_o, {4{16'h4200}});
         check($sformatf("hold_rdy%0d", i),
               DW'(in_ready_o), 64'h0);
      end
      release_result();

      // Empty row goes straight to DONE with neutral value
      start(RED_MAX, 16'd0);
      check("len0_valid", DW'(red_valid_o), 64'h1);
      check("len0_res", red_o, {4{16'hFC00}});
      release_result();

      // Clear while a SUM add is in flight
      start(RED_SUM, 16'd2);
      in_valid_i = 1'b1;
      data_i     = {4{16'h3C00}};
      tick();
      in_valid_i = 1'b0;
      clear_i    = 1'b1;
      tick();
      clear_i = 1'b0;
      check("clr_busy", DW'(busy_o), 64'h0);
      check("clr_red", red_o, 64'h0);
      check("clr_valid", DW'(red_valid_o), 64'h0);
      tick();
      tick();
      check("clr_late_red", red_o, 64'h0);
      check("clr_late_busy", DW'(busy_o), 64'h0);

      // Asynchronous reset in the middle of ACC
      start(RED_MAX, 16'd3);
      in_valid_i = 1'b1;
      data_i     = {4{16'h3C00}};
      tick();
      check("mid_red", red_o, {4{16'h3C00}});
      #2;
      rst_i = 1'b1;
      #1;
      check("arst_red", red_o, 64'h0);
      check("arst_rdy", DW'(in_ready_o), 64'h0);
      check("arst_busy", DW'(busy_o), 64'h0);
      check("arst_valid", DW'(red_valid_o), 64'h0);
      in_valid_i = 1'b0;
      tick();
      rst_i = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
